// File: rtl/sine_cosine_horner_if.sv
// Stream interface of the sine/cosine generator: phase in, signed result out.
interface sine_cosine_horner_if #(
  parameter int unsigned G_DWIDTH = 16
);
  logic [G_DWIDTH-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic                cos_sel;
  logic                bypass;
  logic [G_DWIDTH-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (output din, din_valid, cos_sel, bypass, dout_ready,
                  input  din_ready, dout, dout_valid);
  modport slave  (input  din, din_valid, cos_sel, bypass, dout_ready,
                  output din_ready, dout, dout_valid);
endinterface

// File: rtl/sine_cosine_horner.sv
// Fixed-point sin/cos: quadrant folding, then an odd Horner polynomial
// evaluated on a single shared multiplier. One sample in flight.
module sine_cosine_horner #(
  parameter int unsigned G_DWIDTH    = 16,
  parameter int unsigned G_TAPWIDTH  = 18,
  parameter int unsigned G_NUM_TERMS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  sine_cosine_horner_if.slave  bus
);
  localparam int unsigned W    = G_DWIDTH;
  localparam int unsigned T    = G_TAPWIDTH;
  localparam int unsigned N    = G_NUM_TERMS;
  localparam int unsigned AW   = T + 2;
  localparam int unsigned FRAC = W - 2;
  localparam int unsigned MA   = (AW > W) ? AW : W;
  localparam int unsigned PW   = MA + W;
  // Rescale from the coefficient scale 2^(T-3) to the output scale 2^(W-1)
  localparam int          SH   = int'(T) - int'(W) - 2;
  localparam int          SHR  = (SH > 0) ? SH : 0;
  localparam int          SHL  = (SH < 0) ? -SH : 0;
  localparam int          RND  = (2 ** SHR) / 2;
  localparam int unsigned SW   = AW + unsigned'(SHL) + 1;
  localparam int          MAXV = (1 << (W - 1)) - 1;
  localparam logic [W-1:0]   QTR   = W'(1) << (W - 2);
  localparam logic [W-2:0]   QTR_X = (W - 1)'(1) << (W - 2);

  // Taylor coefficient k of sin(pi/2 * x), rounded to nearest at elaboration
  function automatic logic signed [G_TAPWIDTH-1:0] f_coef(input int k);
    real v;
    v = 1.0;
    for (int i = 1; i <= 2 * k + 1; i++) v = v * 1.5707963267948966 / real'(i);
    if ((k % 2) == 1) v = -v;
    v = v * (2.0 ** (G_TAPWIDTH - 3));
    return G_TAPWIDTH'($rtoi((v >= 0.0) ? v + 0.5 : v - 0.5));
  endfunction

  localparam logic signed [T-1:0] C_TAB [8] = '{
    f_coef(0), f_coef(1), f_coef(2), f_coef(3),
    f_coef(4), f_coef(5), f_coef(6), f_coef(7)
  };

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_FOLD, S_SQUARE, S_HORNER, S_FINAL, S_ROUND, S_OUTPUT
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_din_ready, w_din_ready_nxt;
  logic                  r_dout_valid, w_dout_valid_nxt;
  logic [W-1:0]          r_dout, w_dout_nxt;
  logic [W-1:0]          r_din, w_din_nxt;
  logic                  r_cos, w_cos_nxt;
  logic [W-2:0]          r_x, w_x_nxt;
  logic [W-2:0]          r_x2, w_x2_nxt;
  logic                  r_neg, w_neg_nxt;
  logic signed [AW-1:0]  r_acc, w_acc_nxt;
  logic [2:0]            r_k, w_k_nxt;

  logic                  w_accept;
  logic [W-1:0]          w_p;
  logic [1:0]            w_q;
  logic [W-3:0]          w_r;
  logic [W-2:0]          w_x;
  logic signed [MA-1:0]  w_mul_a;
  logic signed [W-1:0]   w_mul_b;
  logic signed [PW-1:0]  w_prod;
  logic signed [PW-1:0]  w_prod_sh;
  logic signed [SW-1:0]  w_round0, w_round, w_sat;
  logic [W-1:0]          w_res;

  assign w_accept       = bus.din_valid & r_din_ready;
  assign bus.din_ready  = r_din_ready;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;

  // Quadrant folding: cosine is sine advanced by a quarter turn
  assign w_p = r_din + (r_cos ? QTR : '0);
  assign w_q = w_p[W-1:W-2];
  assign w_r = w_p[W-3:0];
  assign w_x = w_q[0] ? (QTR_X - (W - 1)'(w_r)) : (W - 1)'(w_r);

  // Shared multiplier operand select
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_SQUARE: begin w_mul_a = MA'(r_x);   w_mul_b = W'(r_x);  end
      S_HORNER: begin w_mul_a = MA'(r_acc); w_mul_b = W'(r_x2); end
      S_FINAL:  begin w_mul_a = MA'(r_acc); w_mul_b = W'(r_x);  end
      default:  ;
    endcase
  end

  assign w_prod    = PW'(w_mul_a) * PW'(w_mul_b);
  assign w_prod_sh = w_prod >>> FRAC;

  // Output rescale with round-half-up, symmetric saturation and sign restore
  always_comb begin
    w_round0 = (SW'(r_acc) + SW'(RND)) >>> SHR;
    w_round  = w_round0 <<< SHL;
    if (w_round > SW'(MAXV))       w_sat = SW'(MAXV);
    else if (w_round < SW'(-MAXV)) w_sat = SW'(-MAXV);
    else                           w_sat = w_round;
    w_res = r_neg ? W'(-w_sat) : W'(w_sat);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT:   w_state_nxt = S_IDLE;
        S_IDLE:   if (w_accept) w_state_nxt = bus.bypass ? S_OUTPUT : S_FOLD;
        S_FOLD:   w_state_nxt = S_SQUARE;
        S_SQUARE: w_state_nxt = S_HORNER;
        S_HORNER: if (r_k == 3'd0) w_state_nxt = S_FINAL;
        S_FINAL:  w_state_nxt = S_ROUND;
        S_ROUND:  w_state_nxt = S_OUTPUT;
        S_OUTPUT: if (bus.dout_ready) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_INIT;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    w_din_ready_nxt  = r_din_ready;
    w_dout_valid_nxt = r_dout_valid;
    w_dout_nxt       = r_dout;
    w_din_nxt        = r_din;
    w_cos_nxt        = r_cos;
    w_x_nxt          = r_x;
    w_x2_nxt         = r_x2;
    w_neg_nxt        = r_neg;
    w_acc_nxt        = r_acc;
    w_k_nxt          = r_k;
    if (!enable) begin
      w_din_ready_nxt  = 1'b0;
      w_dout_valid_nxt = 1'b0;
      w_dout_nxt       = '0;
    end else begin
      case (r_state)
        S_INIT: w_din_ready_nxt = 1'b1;
        S_IDLE: begin
          if (w_accept) begin
            w_din_ready_nxt = 1'b0;
            w_din_nxt       = bus.din;
            w_cos_nxt       = bus.cos_sel;
            if (bus.bypass) begin
              w_dout_nxt       = bus.din;
              w_dout_valid_nxt = 1'b1;
            end
          end
        end
        S_FOLD: begin
          w_x_nxt   = w_x;
          w_neg_nxt = w_q[1];
        end
        S_SQUARE: begin
          w_x2_nxt  = (W - 1)'(w_prod_sh);
          w_acc_nxt = AW'(C_TAB[N-1]);
          w_k_nxt   = 3'(N - 2);
        end
        S_HORNER: begin
          w_acc_nxt = AW'(C_TAB[r_k]) + AW'(w_prod_sh);
          if (r_k != 3'd0) w_k_nxt = r_k - 3'd1;
        end
        S_FINAL: w_acc_nxt = AW'(w_prod_sh);
        S_ROUND: begin
          w_dout_nxt       = w_res;
          w_dout_valid_nxt = 1'b1;
        end
        S_OUTPUT: begin
          if (bus.dout_ready) begin
            w_dout_valid_nxt = 1'b0;
            w_din_ready_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_din_ready  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_din        <= '0;
      r_cos        <= 1'b0;
      r_x          <= '0;
      r_x2         <= '0;
      r_neg        <= 1'b0;
      r_acc        <= '0;
      r_k          <= '0;
    end else begin
      r_din_ready  <= w_din_ready_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_dout       <= w_dout_nxt;
      r_din        <= w_din_nxt;
      r_cos        <= w_cos_nxt;
      r_x          <= w_x_nxt;
      r_x2         <= w_x2_nxt;
      r_neg        <= w_neg_nxt;
      r_acc        <= w_acc_nxt;
      r_k          <= w_k_nxt;
    end
  end
endmodule

// File: tb/tb_sine_cosine_horner.sv
// Self-checking bench for sine_cosine_horner (W=16, T=18, 5 terms).
module tb_sine_cosine_horner;
  localparam int LAT = 8;
  localparam int TOL = 4;  // Horner steps truncate toward -inf at each stage

  logic clk;
  logic reset;
  logic enable;
  int   n_vec;
  int   n_err;

  sine_cosine_horner_if #(.G_DWIDTH(16)) bus ();

  sine_cosine_horner #(
    .G_DWIDTH(16), .G_TAPWIDTH(18), .G_NUM_TERMS(5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] din;
    bit          cos_sel;
    bit          bypass;
    int          exp;
    int          tol;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  // Ideal sin/cos scaled to Q1.15, rounded, clamped to the symmetric range
  function automatic int ref_trig(input logic [15:0] d, input bit c);
    real ph;
    real v;
    int  r;
    ph = 2.0 * 3.14159265358979 * real'(d) / 65536.0;
    v  = (c ? $cos(ph) : $sin(ph)) * 32768.0;
    r  = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int diff;
    n_vec++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] d, input bit c, input bit b);
    int guard;
    guard = 0;
    while (bus.din_ready !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) chk("din_ready_timeout", 0, 1, 0);
    bus.din       = d;
    bus.cos_sel   = c;
    bus.bypass    = b;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    bus.din       = 16'($urandom);
    bus.cos_sel   = 1'($urandom);
    bus.bypass    = 1'($urandom);
  endtask

  task automatic do_sample(input logic [15:0] d, input bit c, input bit b, input int hold,
                           input int exp, input int tol, input int exp_lat, input string tag);
    int lat;
    int res;
    int stable;
    accept(d, c, b);
    bus.dout_ready = 1'($urandom);
    lat = 0;
    while (bus.dout_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    bus.dout_ready = 1'b0;
    res = int'($signed(bus.dout));
    chk({tag, "_dout"}, res, exp, tol);
    chk({tag, "_lat"}, lat, exp_lat, 0);
    stable = 0;
    bus.din_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.dout_valid === 1'b1 && int'($signed(bus.dout)) == res && bus.din_ready === 1'b0)
        stable++;
    end
    if (hold > 0) chk({tag, "_hold"}, stable, hold, 0);
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    chk({tag, "_release"}, int'({bus.din_ready === 1'b1, bus.dout_valid === 1'b1}), 2, 0);
  endtask

  initial begin
    logic [15:0] d;
    bit          c;
    bit          b;
    int          hold;
    int          exp;
    int          cnt;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    enable = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.cos_sel = 1'b0;
    bus.bypass = 1'b0;
    bus.dout_ready = 1'b0;

    vecs[0] = '{16'h0000, 1'b0, 1'b0,      0, 1, LAT};
    vecs[1] = '{16'h4000, 1'b0, 1'b0,  32767, 0, LAT};
    vecs[2] = '{16'h8000, 1'b0, 1'b0,      0, 1, LAT};
    vecs[3] = '{16'hC000, 1'b0, 1'b0, -32767, 0, LAT};
    vecs[4] = '{16'h2000, 1'b0, 1'b0,  23170, 2, LAT};
    vecs[5] = '{16'h0000, 1'b1, 1'b0,  32767, 0, LAT};
    vecs[6] = '{16'h4000, 1'b1, 1'b0,      0, 1, LAT};
    vecs[7] = '{16'h1234, 1'b0, 1'b1,   4660, 0, 0};
    vecs[8] = '{16'h6000, 1'b0, 1'b0,  23170, 2, LAT};
    vecs[9] = '{16'hA000, 1'b1, 1'b0, -23170, 2, LAT};

    // Reset values and release
    step(); step();
    chk("rst_din_ready", int'(bus.din_ready === 1'b0), 1, 0);
    chk("rst_dout_valid", int'(bus.dout_valid === 1'b0), 1, 0);
    chk("rst_dout", int'(bus.dout === 16'h0000), 1, 0);
    reset = 1'b0;
    chk("rel_din_ready_low", int'(bus.din_ready === 1'b0), 1, 0);
    step(); step();
    chk("rel_din_ready_high", int'(bus.din_ready === 1'b1), 1, 0);

    // Directed table
    for (int i = 0; i < 10; i++)
      do_sample(vecs[i].din, vecs[i].cos_sel, vecs[i].bypass, 0,
                vecs[i].exp, vecs[i].tol, vecs[i].lat, $sformatf("vec%0d", i));

    // Long backpressure
    do_sample(16'h2000, 1'b0, 1'b0, 20, 23170, 2, LAT, "bp20");

    // Async reset in the middle of the Horner loop
    accept(16'h2000, 1'b0, 1'b0);
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("midrst_valid", int'(bus.dout_valid === 1'b0), 1, 0);
    chk("midrst_ready", int'(bus.din_ready === 1'b0), 1, 0);
    step(); step();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.dout_valid !== 1'b0) cnt++;
    end
    chk("midrst_no_output", cnt, 0, 0);
    do_sample(16'h4000, 1'b0, 1'b0, 0, 32767, 0, LAT, "after_rst");

    // Synchronous clear via enable in the middle of the Horner loop
    accept(16'h2000, 1'b0, 1'b0);
    step(); step(); step();
    enable = 1'b0;
    step();
    chk("dis_valid", int'(bus.dout_valid === 1'b0), 1, 0);
    chk("dis_ready", int'(bus.din_ready === 1'b0), 1, 0);
    step();
    enable = 1'b1;
    chk("reen_ready_low", int'(bus.din_ready === 1'b0), 1, 0);
    step();
    chk("reen_ready_high", int'(bus.din_ready === 1'b1), 1, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.dout_valid !== 1'b0) cnt++;
    end
    chk("dis_no_output", cnt, 0, 0);
    do_sample(16'h4000, 1'b0, 1'b0, 0, 32767, 0, LAT, "after_dis");

    // Randomized phases against the ideal model
    for (int i = 0; i < 150; i++) begin
      d    = 16'($urandom);
      c    = 1'($urandom);
      b    = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(0, 3);
      exp  = b ? int'($signed(d)) : ref_trig(d, c);
      do_sample(d, c, b, hold, exp, b ? 0 : TOL, b ? 0 : LAT, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
